ultrasonic_echo_receiver: RTL

- Receive-side companion to the ultrasonic transmitter: times the interval from the transmitter's `burstStart` strobe to the first qualified 40 kHz echo on the digitised receiver comparator line.
- Reports time-of-flight in SYS_CLK cycles, or a timeout if no echo qualifies.
- Sits between the receiver comparator GPIO and the distance-computation logic, one instance per transmit/receive pair.

---
 rtl/ultrasonic_echo_receiver.sv | 90 +++++++++
 1 files changed

// File: rtl/ultrasonic_echo_receiver.sv
// ultrasonic_echo_receiver: times burstStart to first qualified 40 kHz echo in SYS_CLK cycles
module ultrasonic_echo_receiver #(
  parameter int BLANK_CYCLES   = 25000,
  parameter int TIMEOUT_CYCLES = 700000,
  parameter int QUAL_EDGES     = 4,
  parameter int EDGE_GAP_MAX   = 1500,
  parameter int TOF_WIDTH      = 21
) (
  input  logic                 SYS_CLK,
  input  logic                 RST,
  input  logic                 ON,
  input  logic                 burstStart,
  input  logic                 echoInput,
  output logic [TOF_WIDTH-1:0] tofCount,
  output logic                 tofValid,
  output logic                 timeout,
  output logic                 busy
);
  localparam int CW = $clog2(QUAL_EDGES + 1);
  typedef enum logic [1:0] {IDLE, BLANK, LISTEN, QUALIFY} state_t;
  state_t state, state_n;
  logic sync1, sync2, prev, rise, start, accept, expire;
  logic [TOF_WIDTH-1:0] timer, cand, cand_n, gap, gap_n, gap_inc, acc_val;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  assign rise    = sync2 & ~prev;
  assign start   = burstStart & ON;
  assign busy    = state != IDLE;
  assign gap_inc = gap + TOF_WIDTH'(1);
  assign cnt_inc = cnt + CW'(1);
  assign acc_val = state == LISTEN ? timer : cand;
  // next-state: blanking, candidate capture, edge qualification, expiry, restart and enable
  always_comb begin
    state_n = state;
    cand_n  = cand;
    cnt_n   = cnt;
    gap_n   = gap;
    accept  = 1'b0;
    case (state)
      BLANK: state_n = timer == TOF_WIDTH'(BLANK_CYCLES) ? LISTEN : BLANK;
      LISTEN: if (rise) begin
        cand_n  = timer;
        cnt_n   = CW'(1);
        gap_n   = '0;
        accept  = QUAL_EDGES == 1;
        state_n = QUALIFY;
      end
      QUALIFY: begin
        gap_n = gap_inc;
        if (rise && gap_inc <= TOF_WIDTH'(EDGE_GAP_MAX)) begin
          cnt_n  = cnt_inc;
          gap_n  = '0;
          accept = cnt_inc == CW'(QUAL_EDGES);
        end else if (gap_inc > TOF_WIDTH'(EDGE_GAP_MAX)) begin
          state_n = LISTEN;
          cnt_n   = '0;
          gap_n   = '0;
        end
      end
      default: ;
    endcase
    expire = busy && timer == TOF_WIDTH'(TIMEOUT_CYCLES) && !accept;
    if (accept || expire) state_n = IDLE;
    if (start) state_n = BLANK;
    if (!ON) state_n = IDLE;
  end
  // registers: synchroniser, timer, qualification state and result pulses
  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      state    <= IDLE;
      {sync1, sync2, prev} <= '0;
      timer    <= '0;
      cand     <= '0;
      cnt      <= '0;
      gap      <= '0;
      tofCount <= '0;
      tofValid <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      {sync1, sync2, prev} <= {echoInput, sync1, sync2};
      state    <= state_n;
      timer    <= start ? '0 : busy ? timer + TOF_WIDTH'(1) : timer;
      cand     <= cand_n;
      cnt      <= start ? '0 : cnt_n;
      gap      <= start ? '0 : gap_n;
      tofValid <= accept & ON;
      tofCount <= accept & ON ? acc_val : tofCount;
      timeout  <= expire & ~start & ON;
    end
  end
endmodule
